// File: rtl/card_dealer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// card_dealer_if : player buttons and dealt-hand outputs of card_dealer. Rev 1.0
// ----------------------------------------------------------------------------
interface card_dealer_if;
    logic       deal_btn;
    logic       hit_btn;
    logic       stand_btn;
    logic [3:0] first_card;
    logic [3:0] second_card;
    logic [3:0] third_card;
    logic [3:0] fourth_card;
    logic [5:0] hand_total;
    logic       bust;
    logic       busy;
    logic       reset_pulse;

    modport master (
        output deal_btn, hit_btn, stand_btn,
        input  first_card, second_card, third_card, fourth_card,
        input  hand_total, bust, busy, reset_pulse
    );

    modport slave (
        input  deal_btn, hit_btn, stand_btn,
        output first_card, second_card, third_card, fourth_card,
        output hand_total, bust, busy, reset_pulse
    );
endinterface
`default_nettype wire

// File: rtl/card_dealer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// card_dealer : LFSR-driven dealer FSM, up to four cards per round. Rev 1.0
// Optional macro CARD_DEALER_ACE_SOFT_EN counts one ace as 11 when it fits.
// ----------------------------------------------------------------------------
module card_dealer #(
    parameter int          DEAL_GAP = 50_000_000,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    card_dealer_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DEAL1 = 3'd1;
    localparam logic [2:0] S_DEAL2 = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_HIT   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int             GAP_W      = 27;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(DEAL_GAP - 1);
    localparam logic [15:0]    LFSR_TAPS  = 16'hB400;

    logic [2:0]       state_q, state_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic [15:0]      lfsr_q,  lfsr_d;
    logic [3:0][3:0]  cards_q, cards_d;

    logic [3:0] lfsr_nib;
    logic [3:0] draw;
    logic       gap_done;
    logic [5:0] raw_sum;
    logic [5:0] hand_total;
    logic       bust;

    // Low nibble 0..15 folded into 1..10 without a divider.
    assign lfsr_nib = lfsr_q[3:0];
    assign draw     = (lfsr_nib >= 4'd10) ? (lfsr_nib - 4'd9) : (lfsr_nib + 4'd1);
    assign gap_done = (gap_q == '0);

    assign raw_sum = {2'b00, cards_q[0]} + {2'b00, cards_q[1]}
                   + {2'b00, cards_q[2]} + {2'b00, cards_q[3]};

`ifdef CARD_DEALER_ACE_SOFT_EN
    logic has_ace;
    assign has_ace    = (cards_q[0] == 4'd1) || (cards_q[1] == 4'd1)
                     || (cards_q[2] == 4'd1) || (cards_q[3] == 4'd1);
    assign hand_total = (has_ace && (raw_sum <= 6'd11)) ? (raw_sum + 6'd10) : raw_sum;
`else
    assign hand_total = raw_sum;
`endif

    assign bust = (hand_total > 6'd21);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cards_d = cards_q;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & LFSR_TAPS);

        case (state_q)
            S_IDLE: begin
                if (bus.deal_btn) begin
                    cards_d = '0;
                    gap_d   = GAP_RELOAD;
                    state_d = S_DEAL1;
                end
            end
            S_DEAL1: begin
                if (gap_done) begin
                    cards_d[0] = draw;
                    gap_d      = GAP_RELOAD;
                    state_d    = S_DEAL2;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DEAL2: begin
                if (gap_done) begin
                    cards_d[1] = draw;
                    gap_d      = GAP_RELOAD;
                    state_d    = S_WAIT;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (bust || bus.stand_btn) begin
                    state_d = S_DONE;
                end else if (bus.hit_btn) begin
                    gap_d   = GAP_RELOAD;
                    state_d = S_HIT;
                end
            end
            S_HIT: begin
                if (gap_done) begin
                    gap_d = GAP_RELOAD;
                    // Dealt cards are never 0, so an empty third slot marks the target.
                    if (cards_q[2] == 4'd0) begin
                        cards_d[2] = draw;
                        state_d    = S_WAIT;
                    end else begin
                        cards_d[3] = draw;
                        state_d    = S_DONE;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            lfsr_q  <= SEED;
            cards_q <= '0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            lfsr_q  <= lfsr_d;
            cards_q <= cards_d;
        end
    end

    assign bus.first_card  = cards_q[0];
    assign bus.second_card = cards_q[1];
    assign bus.third_card  = cards_q[2];
    assign bus.fourth_card = cards_q[3];
    assign bus.hand_total  = hand_total;
    assign bus.bust        = bust;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.reset_pulse = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_card_dealer.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_card_dealer : randomized rounds against a hand-level dealer model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_card_dealer;

    localparam int          G      = 4;
    localparam logic [15:0] SEED_V = 16'hACE1;

    typedef struct packed {
        int          cyc;
        logic [15:0] c;
        logic        busy;
        logic        rp;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    card_dealer_if dif ();

    card_dealer #(.DEAL_GAP(G), .SEED(SEED_V)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc;
    ev_t exp_q[$];

    // Edges seen since reset was last released.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    function automatic logic [15:0] lfsr_at(int steps);
        logic [15:0] l;
        l = SEED_V;
        repeat (steps) l = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
        return l;
    endfunction

    // Card captured at edge e uses the LFSR value held during the preceding cycle.
    function automatic int card_at(int e);
        logic [15:0] l;
        l = lfsr_at(e - 1);
        return (int'(l[3:0]) % 10) + 1;
    endfunction

    function automatic int model_total(logic [15:0] c);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'(c[i*4 +: 4]);
`ifdef CARD_DEALER_ACE_SOFT_EN
        begin
            bit ace;
            ace = 1'b0;
            for (int i = 0; i < 4; i++) if (c[i*4 +: 4] == 4'd1) ace = 1'b1;
            if (ace && (s + 10 <= 21)) s += 10;
        end
`endif
        return s;
    endfunction

    task automatic cmp(string nm, int act, int ex);
        n_cmp++;
        if (act != ex) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cyc %0d",
                     nm, act, act, ex, ex, cyc);
        end
    endtask

    task automatic push(int c, logic [15:0] cards, bit b, bit r);
        ev_t e;
        e.cyc = c; e.c = cards; e.busy = b; e.rp = r;
        exp_q.push_back(e);
    endtask

    // Monitor: any change on the visible hand, busy, or a reset_pulse is one event.
    initial begin
        logic [15:0] prev_c, cur;
        logic        prev_b;
        ev_t         e;
        int          t;
        prev_c = '0;
        prev_b = 1'b0;
        forever begin
            @(negedge clk);
            cur = {dif.fourth_card, dif.third_card, dif.second_card, dif.first_card};
            if (rst && (cur != prev_c || dif.busy != prev_b || dif.reset_pulse)) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_event: got cards=%h busy=%0b rp=%0b expected none at cyc %0d",
                             cur, dif.busy, dif.reset_pulse, cyc);
                end else begin
                    e = exp_q.pop_front();
                    t = model_total(e.c);
                    cmp("event_cycle", cyc, e.cyc);
                    cmp("cards", int'(cur), int'(e.c));
                    cmp("hand_total", int'(dif.hand_total), t);
                    cmp("bust", int'(dif.bust), int'(t > 21));
                    cmp("busy", int'(dif.busy), int'(e.busy));
                    cmp("reset_pulse", int'(dif.reset_pulse), int'(e.rp));
                end
            end
            prev_c = cur;
            prev_b = dif.busy;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic press(bit d, bit h, bit s);
        dif.deal_btn  = d;
        dif.hit_btn   = h;
        dif.stand_btn = s;
        @(negedge clk);
        dif.deal_btn  = 1'b0;
        dif.hit_btn   = 1'b0;
        dif.stand_btn = 1'b0;
    endtask

    // Random button noise while the dealer is busy capturing; all of it must be dropped.
    task automatic noise_until(int cap);
        while (cyc < cap) begin
            if ($urandom_range(0, 3) == 0)
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                tick();
        end
    endtask

    task automatic check_reset(string tag);
        cmp({tag, "_first"},  int'(dif.first_card),  0);
        cmp({tag, "_second"}, int'(dif.second_card), 0);
        cmp({tag, "_third"},  int'(dif.third_card),  0);
        cmp({tag, "_fourth"}, int'(dif.fourth_card), 0);
        cmp({tag, "_total"},  int'(dif.hand_total),  0);
        cmp({tag, "_bust"},   int'(dif.bust),        0);
        cmp({tag, "_busy"},   int'(dif.busy),        0);
        cmp({tag, "_rp"},     int'(dif.reset_pulse), 0);
    endtask

    task automatic play_round(bit abort);
        logic [15:0] mc;
        int          e, cap, n, a;

        // Presses in IDLE other than deal must be ignored.
        repeat ($urandom_range(1, 4)) begin
            if ($urandom_range(0, 1) == 1) press(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else                           tick();
        end

        mc = '0;
        e  = cyc + 1;
        push(e, mc, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);

        cap = e + G;
        mc[3:0] = 4'(card_at(cap));
        push(cap, mc, 1'b1, 1'b0);
        noise_until(cap);

        if (abort) begin
            repeat ($urandom_range(0, G - 2)) tick();
            #2 rst = 1'b0;
            #1 check_reset("abort");
            exp_q.delete();
            tick();
            tick();
            rst = 1'b1;
            return;
        end

        cap = cap + G;
        mc[7:4] = 4'(card_at(cap));
        push(cap, mc, 1'b1, 1'b0);
        noise_until(cap);
        n = 2;

        forever begin
            repeat ($urandom_range(0, 3)) tick();
            a = $urandom_range(0, 9);
            e = cyc + 1;
            if (a <= 2) begin
                // a==2 pulses hit together with stand; stand must win.
                push(e, mc, 1'b1, 1'b1);
                push(e + 1, mc, 1'b0, 1'b0);
                press(1'b0, (a == 2), 1'b1);
                tick();
                return;
            end
            cap = e + G;
            mc[n*4 +: 4] = 4'(card_at(cap));
            n++;
            if (n == 4) begin
                push(cap, mc, 1'b1, 1'b1);
                push(cap + 1, mc, 1'b0, 1'b0);
            end else begin
                push(cap, mc, 1'b1, 1'b0);
                if (model_total(mc) > 21) begin
                    push(cap + 1, mc, 1'b1, 1'b1);
                    push(cap + 2, mc, 1'b0, 1'b0);
                end
            end
            press(1'b0, 1'b1, 1'b0);
            noise_until(cap);
            if (n == 4) begin
                tick();
                return;
            end
            if (model_total(mc) > 21) begin
                tick();
                tick();
                return;
            end
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        dif.deal_btn  = 1'b0;
        dif.hit_btn   = 1'b0;
        dif.stand_btn = 1'b0;
        rst = 1'b0;
        #12 check_reset("por");
        @(negedge clk);
        rst = 1'b1;
        for (int r = 0; r < 48; r++) play_round(r % 7 == 3);
        repeat (6) tick();
        cmp("queue_drained", exp_q.size(), 0);
        summary();
        $finish;
    end

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        summary();
        $finish;
    end

endmodule
`default_nettype wire
